// File: rtl/servo_slew_ctrl.sv
// servo_slew_ctrl: rate-limited position command generator for the servo PWM block.
// A new target is taken from a one-deep pending slot only on a frame boundary.
// The output VALUE then moves toward that target by at most i_step counts per frame.
// Optional build macro: SERVO_CLAMP_EN clamps each accepted target to [MIN_VALUE, MAX_VALUE].
module servo_slew_ctrl #(
    parameter int          FRAME_TICKS = 320000,
    parameter logic [9:0]  CENTER      = 10'h1FF,
    parameter logic [9:0]  MIN_VALUE   = 10'h000,
    parameter logic [9:0]  MAX_VALUE   = 10'h3FF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [9:0]  i_target,
    input  logic        i_target_valid,
    output logic        o_target_ready,
    input  logic [5:0]  i_step,
    input  logic        i_enable,
    output logic [9:0]  o_value,
    output logic        o_at_target,
    output logic        o_frame_tick
);

    localparam int             CW         = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [CW-1:0]  LAST_COUNT = CW'(FRAME_TICKS - 1);

    // Motion state: IDLE while holding at target, MOVING while a slew is in progress
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_MOVING = 1'b1;

    // An inverted clamp window would silently pin every target; refuse to elaborate it
    if (MIN_VALUE > MAX_VALUE) begin : g_bad_clamp_range
        $error("servo_slew_ctrl: MIN_VALUE must not exceed MAX_VALUE");
    end

    logic [CW-1:0]      r_frame_cnt;
    logic [9:0]         r_value;
    logic [9:0]         r_active;
    logic [9:0]         r_pend;
    logic               r_pend_valid;
    logic               r_at_target;
    logic [0:0]         r_state;

    logic               w_frame_tick;
    logic               w_xfer;
    logic               w_update;
    logic               w_consume;
    logic [9:0]         w_target_in;
    logic [9:0]         w_new_active;
    logic signed [10:0] w_diff;
    logic [10:0]        w_abs_diff;
    logic [9:0]         w_slewed;
    logic [9:0]         w_value_next;
    logic [9:0]         w_active_next;
    logic               w_pend_valid_next;
    logic [0:0]         w_state_next;

    assign w_frame_tick   = (r_frame_cnt == LAST_COUNT);
    assign o_frame_tick   = w_frame_tick;
    assign o_target_ready = ~r_pend_valid;
    assign o_value        = r_value;
    assign o_at_target    = r_at_target;

    // A transfer can only happen while the slot is empty, a consume only while it is full,
    // so the two never coincide.
    assign w_xfer    = i_target_valid & ~r_pend_valid;
    assign w_update  = w_frame_tick & i_enable;
    assign w_consume = w_update & r_pend_valid;

    // Frame counter: free-running 0..FRAME_TICKS-1, independent of i_enable
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_tick) begin
            r_frame_cnt <= '0;
        end else begin
            r_frame_cnt <= r_frame_cnt + 1'b1;
        end
    end

    // Incoming target conditioning before it enters the pending slot
    always_comb begin
        w_target_in = i_target;
`ifdef SERVO_CLAMP_EN
        if (i_target < MIN_VALUE) begin
            w_target_in = MIN_VALUE;
        end else if (i_target > MAX_VALUE) begin
            w_target_in = MAX_VALUE;
        end
`endif
    end

    // Step computation against the target that becomes active at this boundary
    assign w_new_active = w_consume ? r_pend : r_active;
    assign w_diff       = $signed({1'b0, w_new_active}) - $signed({1'b0, r_value});
    assign w_abs_diff   = w_diff[10] ? 11'(-w_diff) : 11'(w_diff);

    // Move all the way when within one step (or unlimited), else one step toward target.
    // The overshoot branch is only taken when |diff| > step, so the add/subtract cannot wrap.
    always_comb begin
        w_slewed = w_new_active;
        if ((i_step != 6'd0) && (w_abs_diff > {5'b0, i_step})) begin
            if (w_diff[10]) begin
                w_slewed = r_value - {4'b0, i_step};
            end else begin
                w_slewed = r_value + {4'b0, i_step};
            end
        end
    end

    assign w_value_next  = w_update ? w_slewed : r_value;
    assign w_active_next = w_update ? w_new_active : r_active;

    // Pending slot occupancy for the next cycle
    always_comb begin
        w_pend_valid_next = r_pend_valid;
        if (w_xfer) begin
            w_pend_valid_next = 1'b1;
        end else if (w_consume) begin
            w_pend_valid_next = 1'b0;
        end
    end

    // Motion FSM next-state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_consume && (r_pend != r_value)) begin
                    w_state_next = ST_MOVING;
                end
            end
            default: begin
                if ((w_value_next == w_active_next) && !w_pend_valid_next) begin
                    w_state_next = ST_IDLE;
                end
            end
        endcase
    end

    // Pending slot storage
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend       <= CENTER;
            r_pend_valid <= 1'b0;
        end else begin
            r_pend_valid <= w_pend_valid_next;
            if (w_xfer) begin
                r_pend <= w_target_in;
            end
        end
    end

    // Position, active target, arrival flag and motion state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value     <= CENTER;
            r_active    <= CENTER;
            r_at_target <= 1'b1;
            r_state     <= ST_IDLE;
        end else begin
            r_value     <= w_value_next;
            r_active    <= w_active_next;
            r_at_target <= (w_value_next == w_active_next) && !w_pend_valid_next;
            r_state     <= w_state_next;
        end
    end

endmodule

// File: tb/tb_servo_slew_ctrl.sv
// Directed bench for servo_slew_ctrl with FRAME_TICKS=100.
// Expected VALUE sequence is queued when a target is sent and popped after each frame tick.
module tb_servo_slew_ctrl;

    localparam int FT = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] target = 10'h000;
    logic       target_valid = 1'b0;
    logic       target_ready;
    logic [5:0] step = 6'd0;
    logic       enable = 1'b1;
    logic [9:0] value;
    logic       at_target;
    logic       frame_tick;

    int n_cmp = 0;
    int n_fail = 0;
    logic [9:0] exp_q[$];

    servo_slew_ctrl #(
        .FRAME_TICKS (FT),
        .CENTER      (10'h1FF),
        .MIN_VALUE   (10'h000),
        .MAX_VALUE   (10'h300)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_target       (target),
        .i_target_valid (target_valid),
        .o_target_ready (target_ready),
        .i_step         (step),
        .i_enable       (enable),
        .o_value        (value),
        .o_at_target    (at_target),
        .o_frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_value(input string tag);
        logic [9:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {22'd0, value}, {22'd0, e});
        end
        $display("txn %s: value=0x%0h at_target=%0b ready=%0b", tag, value, at_target, target_ready);
    endtask

    // Wait for the next frame tick, then land #1 after the edge that applies it
    task automatic wait_frame_tick(input string tag);
        logic [9:0] v0;
        bit moved;
        bit seen;
        v0 = value;
        moved = 0;
        seen = 0;
        for (int n = 0; n < 250; n++) begin
            @(negedge clk);
            if (value !== v0) moved = 1;
            if (frame_tick) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_tick_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_midframe_hold"}, {31'd0, moved}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_target(input logic [9:0] t, output int waited);
        bit ok;
        ok = 0;
        waited = 0;
        target = t;
        target_valid = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (target_ready) begin
                ok = 1;
                break;
            end
            waited++;
        end
        chk("send_accept", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        target_valid = 1'b0;
        $display("txn send: target=0x%0h waited=%0d", t, waited);
    endtask

    initial begin
        int w;
        int tick_cnt;
        int first_idx;

        // 1: reset and idle
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_value", {22'd0, value}, 32'h1FF);
        chk("rst_at_target", {31'd0, at_target}, 32'd1);
        chk("rst_ready", {31'd0, target_ready}, 32'd1);
        chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        tick_cnt = 0;
        first_idx = -1;
        for (int i = 0; i < 300; i++) begin
            if (frame_tick) begin
                if (first_idx < 0) first_idx = i;
                tick_cnt++;
            end
            @(negedge clk);
            #1;
        end
        chk("idle_tick_count", tick_cnt, 32'd3);
        chk("idle_first_tick", first_idx, 32'd99);
        chk("idle_value", {22'd0, value}, 32'h1FF);
        chk("idle_at_target", {31'd0, at_target}, 32'd1);
        @(posedge clk);
        #1;

        // 2: STEP=16 slew from 0x1FF to 0x23F
        step = 6'd16;
        send_target(10'h23F, w);
        exp_q.push_back(10'h20F);
        exp_q.push_back(10'h21F);
        exp_q.push_back(10'h22F);
        exp_q.push_back(10'h23F);
        chk("s2_pending_ready", {31'd0, target_ready}, 32'd0);
        wait_frame_tick("s2_f1");
        check_value("s2_f1");
        chk("s2_f1_at_target", {31'd0, at_target}, 32'd0);
        chk("s2_f1_ready", {31'd0, target_ready}, 32'd1);
        wait_frame_tick("s2_f2");
        check_value("s2_f2");
        wait_frame_tick("s2_f3");
        check_value("s2_f3");
        chk("s2_f3_at_target", {31'd0, at_target}, 32'd0);
        wait_frame_tick("s2_f4");
        check_value("s2_f4");
        chk("s2_f4_at_target", {31'd0, at_target}, 32'd1);

        // 3: STEP=0 jump
        step = 6'd0;
        send_target(10'h3FF, w);
        exp_q.push_back(10'h3FF);
        wait_frame_tick("s3");
        check_value("s3");
        chk("s3_at_target", {31'd0, at_target}, 32'd1);

        // 4: back-to-back targets, second stalls until the slot frees at a tick
        send_target(10'h100, w);
        exp_q.push_back(10'h100);
        exp_q.push_back(10'h080);
        chk("s4_ready_low", {31'd0, target_ready}, 32'd0);
        send_target(10'h080, w);
        chk("s4_second_stalled", {31'd0, (w > 0)}, 32'd1);
        check_value("s4_first");
        wait_frame_tick("s4_second");
        check_value("s4_second");
        chk("s4_at_target", {31'd0, at_target}, 32'd1);

        // 5: ENABLE low freezes VALUE with a pending target for 3 frames
        enable = 1'b0;
        send_target(10'h050, w);
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back(10'h080);
            wait_frame_tick("s5_frozen");
            check_value("s5_frozen");
            chk("s5_ready_low", {31'd0, target_ready}, 32'd0);
            chk("s5_at_target_low", {31'd0, at_target}, 32'd0);
        end
        enable = 1'b1;
        exp_q.push_back(10'h050);
        wait_frame_tick("s5_resume");
        check_value("s5_resume");
        chk("s5_resume_ready", {31'd0, target_ready}, 32'd1);

        // 6: out-of-range target (clamped only when built with the clamp)
        send_target(10'h3FF, w);
`ifdef SERVO_CLAMP_EN
        exp_q.push_back(10'h300);
`else
        exp_q.push_back(10'h3FF);
`endif
        wait_frame_tick("s6_clamp");
        check_value("s6_clamp");

        // Reset mid-frame with a pending target held by ENABLE=0
        enable = 1'b0;
        send_target(10'h010, w);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("s6_rst_value", {22'd0, value}, 32'h1FF);
        chk("s6_rst_ready", {31'd0, target_ready}, 32'd1);
        chk("s6_rst_at_target", {31'd0, at_target}, 32'd1);
        chk("s6_rst_frame_tick", {31'd0, frame_tick}, 32'd0);
        $display("txn reset: value=0x%0h ready=%0b", value, target_ready);
        @(negedge clk);
        rst_n = 1'b1;
        enable = 1'b1;
        exp_q.push_back(10'h1FF);
        wait_frame_tick("s6_pending_lost");
        check_value("s6_pending_lost");
        chk("s6_post_at_target", {31'd0, at_target}, 32'd1);
        chk("s6_queue_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
